// File: rtl/dac_seq_if.sv
// Handshake, sample bus and DAC pin group for dac_seq.
// The sequencer takes the slave side; the requester takes the master side.
`timescale 1ns/1ps
interface dac_seq_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12
);
    logic                     start;
    logic [NUM_CH-1:0]        ch_mask;
    logic [NUM_CH*DATA_W-1:0] data;
    logic                     sync_mode;
    logic                     busy;
    logic                     done;
    logic                     spi_mosi;
    logic                     spi_sck;
    logic                     dac_cs;
    logic                     dac_clr;

    modport master (
        output start, ch_mask, data, sync_mode,
        input  busy, done, spi_mosi, spi_sck, dac_cs, dac_clr
    );

    modport slave (
        input  start, ch_mask, data, sync_mode,
        output busy, done, spi_mosi, spi_sck, dac_cs, dac_clr
    );
endinterface

// File: rtl/dac_seq.sv
// Multi-channel DAC update sequencer: snapshots a channel mask and samples on start,
// then shifts one 32-bit SPI mode-0 command frame per enabled channel, lowest index first.
`timescale 1ns/1ps
module dac_seq #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 12,
    parameter int CLK_DIV    = 2,
    parameter int CLR_CYCLES = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    dac_seq_if.slave  dac_if
);

    localparam int PH_W    = $clog2(CLK_DIV * 2);
    localparam int CNT_MAX = (CLR_CYCLES > 2 * CLK_DIV) ? CLR_CYCLES : 2 * CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [PH_W-1:0]  PH_HIGH = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(2 * CLK_DIV - 1);
    // mosi moves one cycle after SCK falls; with a one-cycle low phase it moves on the fall itself
    localparam logic [PH_W-1:0]  PH_CHG  = (CLK_DIV > 1) ? PH_W'(1) : PH_W'(0);
    localparam logic [CNT_W-1:0] CLR_END = CNT_W'(CLR_CYCLES);
    localparam logic [CNT_W-1:0] DIV_END = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END = CNT_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_CLR,
        S_IDLE,
        S_LOAD,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PH_W-1:0]          ph_q, ph_d;
    logic [5:0]               bit_q, bit_d;
    logic [31:0]              shreg_q, shreg_d;
    logic [NUM_CH-1:0]        mask_q, mask_d;
    logic [NUM_CH*DATA_W-1:0] data_q, data_d;
    logic                     sync_q, sync_d;
    logic                     mosi_q, mosi_d;
    logic                     sck_q, sck_d;
    logic                     cs_q, cs_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     clr_q, clr_d;

    logic [DATA_W-1:0]        data_arr [NUM_CH];
    logic [DATA_W-1:0]        pick_data;
    logic [3:0]               pick_idx;
    logic [NUM_CH-1:0]        mask_rest;
    logic [11:0]              sample;
    logic [3:0]               cmd;
    logic [31:0]              frame;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign data_arr[gi] = data_q[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Lowest set bit of the remaining mask selects the channel for this frame.
    always_comb begin
        pick_idx  = '0;
        pick_data = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                pick_idx  = 4'(i);
                pick_data = data_arr[i];
            end
        end
    end

    assign mask_rest = mask_q & (mask_q - 1'b1);
    assign sample    = 12'(pick_data) << (12 - DATA_W);

    // In simultaneous mode only the final frame of the sequence triggers the update.
    always_comb begin
        if (!sync_q)
            cmd = 4'b0011;
        else if (mask_rest == '0)
            cmd = 4'b0010;
        else
            cmd = 4'b0000;
    end

    assign frame = {8'h00, cmd, pick_idx, sample, 4'h0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        mask_d  = mask_q;
        data_d  = data_q;
        sync_d  = sync_q;
        mosi_d  = mosi_q;

        case (state_q)
            S_CLR: begin
                if (cnt_q == CLR_END) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (dac_if.start) begin
                    mask_d  = dac_if.ch_mask;
                    data_d  = dac_if.data;
                    sync_d  = dac_if.sync_mode;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (mask_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    mask_d  = mask_rest;
                    shreg_d = frame;
                    mosi_d  = frame[31];
                    cnt_d   = '0;
                    state_d = S_CS_SETUP;
                end
            end
            S_CS_SETUP: begin
                if (cnt_q == DIV_END) begin
                    cnt_d   = '0;
                    ph_d    = '0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (bit_q == 6'd31) begin
                        state_d = S_CS_HOLD;
                        cnt_d   = '0;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
                // Bit 31 was presented at CS setup; later bits advance inside the low phase.
                if (state_d == S_SHIFT && ph_d == PH_CHG && bit_d != 6'd0) begin
                    shreg_d = {shreg_q[30:0], 1'b0};
                    mosi_d  = shreg_q[30];
                end
            end
            S_CS_HOLD: begin
                if (cnt_q == DIV_END) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = '0;
                    state_d = (mask_q != '0) ? S_LOAD : S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_CLR;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin outputs are registered from the next state so they are glitch-free.
    always_comb begin
        cs_d   = !(state_d == S_CS_SETUP || state_d == S_SHIFT || state_d == S_CS_HOLD);
        sck_d  = (state_d == S_SHIFT) && (ph_d >= PH_HIGH);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        clr_d  = (state_d != S_CLR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLR;
            cnt_q   <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            sync_q  <= 1'b0;
            mosi_q  <= 1'b0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            sync_q  <= sync_d;
            mosi_q  <= mosi_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
        end
    end

    assign dac_if.busy     = busy_q;
    assign dac_if.done     = done_q;
    assign dac_if.spi_mosi = mosi_q;
    assign dac_if.spi_sck  = sck_q;
    assign dac_if.dac_cs   = cs_q;
    assign dac_if.dac_clr  = clr_q;

endmodule
